mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, between the EX/MEM register and `mem_wb`. It passes ALU results through unchanged. For load and store ops it runs a multi-cycle handshake on the data bus and raises `stallreq` until the access completes. It then presents the write-back triple (`mem_wd`, `mem_wreg`, `mem_wdata`) for `mem_wb` to capture.

---
 rtl/mem_stage_pkg.sv | 52 +++++
 rtl/mem_stage_if.sv | 32 +++
 rtl/mem_align.sv | 97 +++++++++
 rtl/mem_stage.sv | 173 +++++++++++++++++
 tb/tb_mem_stage.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Purpose  : Shared types, bus widths, aluop codes and FSM state encodings for
//            the memory-access pipeline stage and its byte-lane aligner.
// Contents : reg_addr_t / reg_t / aluop_t / dbus_sel_t bus types, write-back
//            reset values, the eight memory aluop codes, mem_state_e, and
//            helper functions that classify an aluop as load / store.
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  // Bus widths
  typedef logic [4:0]  reg_addr_t;  // RegAddrBus
  typedef logic [31:0] reg_t;       // RegBus
  typedef logic [7:0]  aluop_t;     // AluOpBus
  typedef logic [3:0]  dbus_sel_t;  // DBusSelBus

  // Reset / idle values presented to mem_wb
  localparam logic      RstEnable    = 1'b1;
  localparam logic      WriteDisable = 1'b0;
  localparam reg_addr_t NOPRegAddr   = 5'b00000;
  localparam reg_t      ZeroWord     = 32'h0000_0000;

  // Memory aluop codes
  localparam aluop_t EXE_LB_OP  = 8'b1110_0000;
  localparam aluop_t EXE_LBU_OP = 8'b1110_0100;
  localparam aluop_t EXE_LH_OP  = 8'b1110_0001;
  localparam aluop_t EXE_LHU_OP = 8'b1110_0101;
  localparam aluop_t EXE_LW_OP  = 8'b1110_0011;
  localparam aluop_t EXE_SB_OP  = 8'b1110_1000;
  localparam aluop_t EXE_SH_OP  = 8'b1110_1001;
  localparam aluop_t EXE_SW_OP  = 8'b1110_1011;

  // Memory-stage FSM encodings
  typedef enum logic [1:0] {
    MemIdle = 2'd0,
    MemBus  = 2'd1,
    MemDone = 2'd2
  } mem_state_e;

  function automatic logic is_load_op(input aluop_t op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic is_store_op(input aluop_t op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_if
// Purpose  : Data-bus request/response bundle between the memory stage
//            (master) and the data memory / bus fabric (slave).
// Signals  : dbus_ce, dbus_we, dbus_addr, dbus_sel, dbus_wdata  (request)
//            dbus_rdata, dbus_ack                               (response)
// Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic      dbus_ce;
  logic      dbus_we;
  reg_t      dbus_addr;
  dbus_sel_t dbus_sel;
  reg_t      dbus_wdata;
  reg_t      dbus_rdata;
  logic      dbus_ack;

  modport master (
    output dbus_ce, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    input  dbus_rdata, dbus_ack
  );

  modport slave (
    input  dbus_ce, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    output dbus_rdata, dbus_ack
  );

endinterface : mem_stage_if
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_align
// Purpose  : Purely combinational big-endian byte-lane logic for the memory
//            stage: byte enables, replicated store data, sign/zero-extended
//            load data, and misalignment detection.
// Ports    : aluop      in  8  - operation being executed
//            offset     in  2  - low two bits of the effective address
//            reg2       in  32 - store source register
//            rdata      in  32 - raw word returned by the bus
//            sel        out 4  - byte enables (bit 3 = byte offset 0)
//            store_data out 32 - lane-replicated store data
//            load_data  out 32 - extended load result
//            misalign   out 1  - halfword/word access not naturally aligned
// Revision : 1.0 - initial release
// ============================================================================
module mem_align
  import mem_stage_pkg::*;
(
  input  aluop_t    aluop,
  input  logic [1:0] offset,
  input  reg_t      reg2,
  input  reg_t      rdata,
  output dbus_sel_t sel,
  output reg_t      store_data,
  output reg_t      load_data,
  output logic      misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  dbus_sel_t   w_byte_sel;
  dbus_sel_t   w_half_sel;

  // Big-endian lane pick: offset 0 is the most significant byte.
  always_comb begin
    w_byte = rdata[7:0];
    case (offset)
      2'd0:    w_byte = rdata[31:24];
      2'd1:    w_byte = rdata[23:16];
      2'd2:    w_byte = rdata[15:8];
      default: w_byte = rdata[7:0];
    endcase
    w_half     = offset[1] ? rdata[15:0] : rdata[31:16];
    w_byte_sel = 4'b1000 >> offset;
    w_half_sel = offset[1] ? 4'b0011 : 4'b1100;
  end

  always_comb begin
    sel        = 4'b0000;
    store_data = ZeroWord;
    load_data  = ZeroWord;
    misalign   = 1'b0;
    case (aluop)
      EXE_LB_OP: begin
        sel       = w_byte_sel;
        load_data = {{24{w_byte[7]}}, w_byte};
      end
      EXE_LBU_OP: begin
        sel       = w_byte_sel;
        load_data = {24'd0, w_byte};
      end
      EXE_LH_OP: begin
        misalign  = offset[0];
        sel       = w_half_sel;
        load_data = {{16{w_half[15]}}, w_half};
      end
      EXE_LHU_OP: begin
        misalign  = offset[0];
        sel       = w_half_sel;
        load_data = {16'd0, w_half};
      end
      EXE_LW_OP: begin
        misalign  = |offset;
        sel       = 4'b1111;
        load_data = rdata;
      end
      EXE_SB_OP: begin
        sel        = w_byte_sel;
        store_data = {4{reg2[7:0]}};
      end
      EXE_SH_OP: begin
        misalign   = offset[0];
        sel        = w_half_sel;
        store_data = {2{reg2[15:0]}};
      end
      EXE_SW_OP: begin
        misalign   = |offset;
        sel        = 4'b1111;
        store_data = reg2;
      end
      default: ;
    endcase
  end

endmodule : mem_align
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access pipeline stage. Passes ALU results straight
//            through; for loads/stores runs a request/ack handshake on the
//            data bus, freezing the pipeline until the access completes or
//            times out, then presents the write-back triple to mem_wb.
// Params   : TIMEOUT - BUS cycles to wait for dbus_ack before aborting (>=1)
// Ports    : clk, rst                      - clock, sync active-high reset
//            ex_wd/ex_wreg/ex_wdata        - write-back triple from EX/MEM
//            ex_aluop/ex_mem_addr/ex_reg2  - memory op, address, store data
//            mem_wd/mem_wreg/mem_wdata     - write-back triple to mem_wb
//            stallreq                      - pipeline freeze request
//            misalign / bus_err            - one-cycle fault pulses
//            bus                           - data-bus master interface
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic      clk,
  input  logic      rst,
  input  reg_addr_t ex_wd,
  input  logic      ex_wreg,
  input  reg_t      ex_wdata,
  input  aluop_t    ex_aluop,
  input  reg_t      ex_mem_addr,
  input  reg_t      ex_reg2,
  output reg_addr_t mem_wd,
  output logic      mem_wreg,
  output reg_t      mem_wdata,
  output logic      stallreq,
  output logic      misalign,
  output logic      bus_err,
  mem_stage_if.master bus
);

  localparam int               CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  mem_state_e       r_state;
  logic             r_ce;
  logic             r_we;
  reg_t             r_addr;
  dbus_sel_t        r_sel;
  reg_t             r_wdata;
  reg_t             r_load_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_abort;

  dbus_sel_t w_sel;
  reg_t      w_store_data;
  reg_t      w_load_data;
  logic      w_misalign;
  logic      w_is_load;
  logic      w_is_store;
  logic      w_is_mem;

  assign w_is_load  = is_load_op(ex_aluop);
  assign w_is_store = is_store_op(ex_aluop);
  assign w_is_mem   = w_is_load | w_is_store;

  // EX/MEM is frozen while stallreq is high, so the ex_* operands (and hence
  // the address offset) stay valid for formatting the returned data in BUS.
  mem_align u_align (
    .aluop      (ex_aluop),
    .offset     (ex_mem_addr[1:0]),
    .reg2       (ex_reg2),
    .rdata      (bus.dbus_rdata),
    .sel        (w_sel),
    .store_data (w_store_data),
    .load_data  (w_load_data),
    .misalign   (w_misalign)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state  <= MemIdle;
      r_ce     <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= ZeroWord;
      r_sel    <= 4'b0000;
      r_wdata  <= ZeroWord;
      r_load_q <= ZeroWord;
      r_cnt    <= '0;
      r_abort  <= 1'b0;
    end else begin
      case (r_state)
        MemIdle: begin
          if (w_is_mem && !w_misalign) begin
            r_ce    <= 1'b1;
            r_we    <= w_is_store;
            r_addr  <= {ex_mem_addr[31:2], 2'b00};
            r_sel   <= w_sel;
            r_wdata <= w_store_data;
            r_cnt   <= '0;
            r_abort <= 1'b0;
            r_state <= MemBus;
          end
        end
        MemBus: begin
          r_cnt <= r_cnt + 1'b1;
          // Ack is checked first so a same-cycle ack beats the timeout.
          if (bus.dbus_ack) begin
            r_load_q <= w_load_data;
            r_ce     <= 1'b0;
            r_we     <= 1'b0;
            r_state  <= MemDone;
          end else if (r_cnt == c_cnt_last) begin
            r_ce    <= 1'b0;
            r_we    <= 1'b0;
            r_abort <= 1'b1;
            r_state <= MemDone;
          end
        end
        MemDone: begin
          // EX/MEM advances on this edge, so the op cannot be reissued.
          r_abort <= 1'b0;
          r_state <= MemIdle;
        end
        default: r_state <= MemIdle;
      endcase
    end
  end

  always_comb begin
    mem_wd    = ex_wd;
    mem_wreg  = ex_wreg;
    mem_wdata = ex_wdata;
    stallreq  = 1'b0;
    misalign  = 1'b0;
    bus_err   = 1'b0;
    if (rst == RstEnable) begin
      mem_wd    = NOPRegAddr;
      mem_wreg  = WriteDisable;
      mem_wdata = ZeroWord;
    end else begin
      case (r_state)
        MemIdle: begin
          if (w_is_mem) begin
            mem_wreg = WriteDisable;
            if (w_misalign) begin
              // Retire as a NOP without touching the bus.
              misalign = 1'b1;
            end else begin
              stallreq = 1'b1;
            end
          end
        end
        MemBus: begin
          stallreq = 1'b1;
          mem_wreg = WriteDisable;
        end
        MemDone: begin
          mem_wreg  = (w_is_load && !r_abort) ? ex_wreg : WriteDisable;
          mem_wdata = r_load_q;
          bus_err   = r_abort;
        end
        default: mem_wreg = WriteDisable;
      endcase
    end
  end

  assign bus.dbus_ce    = r_ce;
  assign bus.dbus_we    = r_we;
  assign bus.dbus_addr  = r_addr;
  assign bus.dbus_sel   = r_sel;
  assign bus.dbus_wdata = r_wdata;

endmodule : mem_stage
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage: directed cases plus
//            randomized operations compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TB_TIMEOUT = 4;

  logic      clk = 1'b0;
  logic      rst;
  reg_addr_t ex_wd;
  logic      ex_wreg;
  reg_t      ex_wdata;
  aluop_t    ex_aluop;
  reg_t      ex_mem_addr;
  reg_t      ex_reg2;
  reg_addr_t mem_wd;
  logic      mem_wreg;
  reg_t      mem_wdata;
  logic      stallreq;
  logic      misalign;
  logic      bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage_if u_if ();

  mem_stage #(.TIMEOUT(TB_TIMEOUT)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .ex_wd       (ex_wd),
    .ex_wreg     (ex_wreg),
    .ex_wdata    (ex_wdata),
    .ex_aluop    (ex_aluop),
    .ex_mem_addr (ex_mem_addr),
    .ex_reg2     (ex_reg2),
    .mem_wd      (mem_wd),
    .mem_wreg    (mem_wreg),
    .mem_wdata   (mem_wdata),
    .stallreq    (stallreq),
    .misalign    (misalign),
    .bus_err     (bus_err),
    .bus         (u_if.master)
  );

  always #5 clk = ~clk;

  aluop_t mem_ops [8] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
                          EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  aluop_t alu_ops [5] = '{8'h00, 8'h20, 8'h21, 8'h24, 8'h25};

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int op_index(input aluop_t op);
    for (int i = 0; i < 8; i++) if (mem_ops[i] == op) return i;
    return -1;
  endfunction

  function automatic int op_size(input aluop_t op);
    if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
    if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
    return 4;
  endfunction

  // Byte address i (0..3) is enabled by sel bit (3-i).
  function automatic logic [3:0] m_sel(input int sz, input int off);
    logic [3:0] s = 4'b0000;
    for (int i = off; i < off + sz; i++) s[3-i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_store(input int sz, input logic [31:0] r2);
    logic [31:0] lane, w;
    lane = (sz == 4) ? r2 : (r2 & ((32'd1 << (sz * 8)) - 1));
    w = 32'd0;
    for (int k = 0; k < 4; k += sz) w = w | (lane << (k * 8));
    return w;
  endfunction

  function automatic logic [31:0] m_load(input aluop_t op, input int off,
                                         input logic [31:0] rd);
    int sz = op_size(op);
    logic [31:0] v;
    if (sz == 4) return rd;
    v = (rd >> ((4 - sz - off) * 8)) & ((32'd1 << (sz * 8)) - 1);
    if ((op == EXE_LB_OP || op == EXE_LH_OP) && v[sz*8-1])
      v = v | ~((32'd1 << (sz * 8)) - 1);
    return v;
  endfunction

  // ---------------- one operation, cycle by cycle ----------------
  // ack_at: BUS cycle (1-based) on which ack is given; 0 or > TIMEOUT = never.
  task automatic run_op(input aluop_t op, input reg_addr_t wd, input logic wreg,
                        input reg_t wdata, input reg_t addr, input reg_t r2,
                        input reg_t rd, input int ack_at);
    int idx = op_index(op);
    int off = int'(addr[1:0]);
    int sz  = op_size(op);
    bit is_load = (idx >= 0) && (idx < 5);
    bit acked = 0;
    int n = 0;
    ex_aluop = op; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
    ex_mem_addr = addr; ex_reg2 = r2;
    u_if.dbus_ack = 1'($urandom_range(0, 1));  // ignored outside BUS
    u_if.dbus_rdata = $urandom;
    @(negedge clk);
    if (idx < 0) begin
      check_eq("pass_wd", 32'(mem_wd), 32'(wd));
      check_eq("pass_wreg", 32'(mem_wreg), 32'(wreg));
      check_eq("pass_wdata", mem_wdata, wdata);
      check_eq("pass_stall", 32'(stallreq), 32'd0);
      check_eq("pass_misalign", 32'(misalign), 32'd0);
      step();
      return;
    end
    if ((off % sz) != 0) begin
      check_eq("mis_pulse", 32'(misalign), 32'd1);
      check_eq("mis_stall", 32'(stallreq), 32'd0);
      check_eq("mis_wreg", 32'(mem_wreg), 32'd0);
      step();
      @(negedge clk);
      check_eq("mis_no_ce", 32'(u_if.dbus_ce), 32'd0);
      step();
      return;
    end
    check_eq("req_stall", 32'(stallreq), 32'd1);
    check_eq("req_wreg", 32'(mem_wreg), 32'd0);
    while (!acked && n < TB_TIMEOUT) begin
      step();
      n++;
      acked = (n == ack_at);
      u_if.dbus_ack = acked;
      u_if.dbus_rdata = acked ? rd : $urandom;
      @(negedge clk);
      check_eq("bus_ce", 32'(u_if.dbus_ce), 32'd1);
      check_eq("bus_stall", 32'(stallreq), 32'd1);
      check_eq("bus_wreg", 32'(mem_wreg), 32'd0);
      if (n == 1) begin
        check_eq("bus_we", 32'(u_if.dbus_we), 32'(!is_load));
        check_eq("bus_addr", u_if.dbus_addr, {addr[31:2], 2'b00});
        check_eq("bus_sel", 32'(u_if.dbus_sel), 32'(m_sel(sz, off)));
        if (!is_load) check_eq("bus_wdata", u_if.dbus_wdata, m_store(sz, r2));
      end
    end
    step();
    u_if.dbus_ack = 1'($urandom_range(0, 1));
    u_if.dbus_rdata = $urandom;
    @(negedge clk);
    check_eq("done_ce", 32'(u_if.dbus_ce), 32'd0);
    check_eq("done_stall", 32'(stallreq), 32'd0);
    check_eq("done_bus_err", 32'(bus_err), 32'(!acked));
    check_eq("done_wd", 32'(mem_wd), 32'(wd));
    check_eq("done_wreg", 32'(mem_wreg), 32'(is_load && acked && wreg));
    if (is_load && acked) check_eq("done_wdata", mem_wdata, m_load(op, off, rd));
    step();
  endtask

  initial begin
    rst = 1'b1;
    ex_aluop = EXE_LW_OP; ex_wd = 5'd9; ex_wreg = 1'b1; ex_wdata = 32'h5555_AAAA;
    ex_mem_addr = 32'h0000_0100; ex_reg2 = 32'h0; 
    u_if.dbus_ack = 1'b0; u_if.dbus_rdata = 32'h0;
    step();
    step();
    @(negedge clk);
    check_eq("rst_wd", 32'(mem_wd), 32'd0);
    check_eq("rst_wreg", 32'(mem_wreg), 32'd0);
    check_eq("rst_wdata", mem_wdata, 32'd0);
    check_eq("rst_stall", 32'(stallreq), 32'd0);
    check_eq("rst_ce", 32'(u_if.dbus_ce), 32'd0);
    step();
    rst = 1'b0;

    // Directed cases
    run_op(8'h20, 5'd5, 1'b1, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 0);
    run_op(EXE_LB_OP, 5'd3, 1'b1, 32'h0, 32'h0000_0101, 32'h0, 32'h1180_2233, 1);
    run_op(EXE_SH_OP, 5'd4, 1'b1, 32'h0, 32'h0000_0202, 32'hAAAA_5678, 32'h0, 3);
    run_op(EXE_LW_OP, 5'd6, 1'b1, 32'h0, 32'h0000_0103, 32'h0, 32'h0, 1);
    run_op(EXE_LHU_OP, 5'd7, 1'b1, 32'h0, 32'h0000_0300, 32'h0, 32'h0, 0);
    run_op(EXE_LH_OP, 5'd8, 1'b1, 32'h0, 32'h0000_0302, 32'h0, 32'h0000_9ABC,
           TB_TIMEOUT);  // ack on the timeout cycle wins

    // Reset in the middle of a BUS wait, followed by a late ack
    ex_aluop = EXE_LW_OP; ex_mem_addr = 32'h0000_0400; ex_wd = 5'd2; ex_wreg = 1'b1;
    u_if.dbus_ack = 1'b0;
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    check_eq("rbus_wd", 32'(mem_wd), 32'd0);
    check_eq("rbus_wreg", 32'(mem_wreg), 32'd0);
    check_eq("rbus_wdata", mem_wdata, 32'd0);
    check_eq("rbus_stall", 32'(stallreq), 32'd0);
    check_eq("rbus_misalign", 32'(misalign), 32'd0);
    check_eq("rbus_bus_err", 32'(bus_err), 32'd0);
    step();
    rst = 1'b0;
    u_if.dbus_ack = 1'b1;
    u_if.dbus_rdata = 32'hDEAD_BEEF;
    ex_aluop = 8'h25; ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'h0000_CAFE;
    @(negedge clk);
    check_eq("late_ce", 32'(u_if.dbus_ce), 32'd0);
    check_eq("late_stall", 32'(stallreq), 32'd0);
    check_eq("late_wdata", mem_wdata, 32'h0000_CAFE);
    step();
    u_if.dbus_ack = 1'b0;
    @(negedge clk);
    check_eq("late_ce2", 32'(u_if.dbus_ce), 32'd0);
    check_eq("late_bus_err", 32'(bus_err), 32'd0);
    step();

    // Randomized operations
    for (int t = 0; t < 200; t++) begin
      aluop_t op;
      if ($urandom_range(0, 9) < 7) op = mem_ops[$urandom_range(0, 7)];
      else op = alu_ops[$urandom_range(0, 4)];
      run_op(op, 5'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
             $urandom, $urandom_range(0, TB_TIMEOUT + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule : tb_mem_stage
`default_nettype wire
